// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM/owner encodings and default timing parameters
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } own_t;
  localparam int DEF_MEM_LATENCY = 2;
  localparam int DEF_MAX_DM_STREAK = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch (if_*), data (dm_*) and memory (mem_*) signals; slave = arbiter side, master = core/memory side
interface mem_port_arbiter_if #(
  parameter int data_size = 32,
  parameter int mem_size = 16
);
  logic                 if_req;
  logic [mem_size-1:0]  if_addr;
  logic                 if_ack;
  logic [data_size-1:0] if_rdata;
  logic                 dm_req;
  logic                 dm_we;
  logic [mem_size-1:0]  dm_addr;
  logic [data_size-1:0] dm_wdata;
  logic                 dm_ack;
  logic [data_size-1:0] dm_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [mem_size-1:0]  mem_addr;
  logic [data_size-1:0] mem_wdata;
  logic [data_size-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_grant.sv
// mem_port_grant: data-priority winner select (i_if_req, i_dm_req -> o_dm_win) with a streak limit updated on i_eval
module mem_port_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_dm_req,
  input  logic i_eval,
  output logic o_dm_win
);
  logic [3:0] r_streak;
  assign o_dm_win = i_dm_req && !(i_if_req && r_streak == 4'(MAX_DM_STREAK));
  // dm only wins against a waiting fetch below the limit, so the increment saturates by construction
  always_ff @(posedge clk)
    if (rst) r_streak <= '0;
    else if (i_eval) r_streak <= (o_dm_win && i_if_req) ? r_streak + 4'd1 : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports (clk, rst, bus: if_*/dm_* requesters, mem_* memory)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int data_size = 32,
  parameter int mem_size = 16,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  state_t               r_state;
  own_t                 r_own;
  logic                 r_we;
  logic [3:0]           r_cnt;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [mem_size-1:0]  r_mem_addr;
  logic [data_size-1:0] r_mem_wdata;
  logic                 r_if_ack;
  logic                 r_dm_ack;
  logic [data_size-1:0] r_if_rdata;
  logic [data_size-1:0] r_dm_rdata;
  logic                 w_req;
  logic                 w_dm_win;
  logic                 w_rd_done;
  logic                 w_done;
  assign w_req     = bus.if_req | bus.dm_req;
  assign w_rd_done = r_state == WAIT && r_cnt == '0;
  assign w_done    = w_rd_done || (r_state == ISSUE && r_we);
  mem_port_grant #(.MAX_DM_STREAK(MAX_DM_STREAK)) u_grant (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (bus.if_req),
    .i_dm_req (bus.dm_req),
    .i_eval   (r_state == IDLE && w_req),
    .o_dm_win (w_dm_win)
  );
  // mem_addr/mem_wdata double as the latched request fields; acks are raised on the edge into ACK
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_own       <= OWN_IF;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_if_ack <= w_done && r_own == OWN_IF;
      r_dm_ack <= w_done && r_own == OWN_DM;
      if (w_rd_done && r_own == OWN_IF) r_if_rdata <= bus.mem_rdata;
      if (w_rd_done && r_own == OWN_DM) r_dm_rdata <= bus.mem_rdata;
      case (r_state)
        IDLE: if (w_req) begin
          r_own       <= w_dm_win ? OWN_DM : OWN_IF;
          r_we        <= w_dm_win & bus.dm_we;
          r_mem_en    <= 1'b1;
          r_mem_we    <= w_dm_win & bus.dm_we;
          r_mem_addr  <= w_dm_win ? bus.dm_addr : bus.if_addr;
          r_mem_wdata <= w_dm_win ? bus.dm_wdata : '0;
          r_state     <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= 4'(MEM_LATENCY - 1);
          r_state <= r_we ? ACK : WAIT;
        end
        WAIT: begin
          r_cnt   <= r_cnt - 4'd1;
          r_state <= w_rd_done ? ACK : WAIT;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner sequences and random traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam int L = 2;
  localparam int MAXS = 4;
  logic clk;
  logic rst;
  int checks;
  int failures;
  int cyc;
  mem_port_arbiter_if #(.data_size(32), .mem_size(16)) bus ();
  mem_port_arbiter #(.data_size(32), .mem_size(16), .MEM_LATENCY(L), .MAX_DM_STREAK(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  logic [31:0] mem [int];
  logic [31:0] refm [int];
  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a, ~a} ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] memv(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : dflt(a);
  endfunction
  function automatic logic [31:0] refv(input logic [15:0] a);
    return refm.exists(int'(a)) ? refm[int'(a)] : dflt(a);
  endfunction
  task automatic set_mem(input logic [15:0] a, input logic [31:0] d);
    mem[int'(a)] = d;
    refm[int'(a)] = d;
  endtask
  logic p_rst = 1'b1;
  logic p_if_req, p_dm_req, p_dm_we;
  logic [15:0] p_if_addr, p_dm_addr;
  logic [31:0] p_dm_wdata;
  initial cyc = 0;
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    p_rst      <= rst;
    p_if_req   <= bus.if_req;
    p_dm_req   <= bus.dm_req;
    p_dm_we    <= bus.dm_we;
    p_if_addr  <= bus.if_addr;
    p_dm_addr  <= bus.dm_addr;
    p_dm_wdata <= bus.dm_wdata;
  end
  int rd_due = -1;
  logic [15:0] rd_addr;
  bit m_busy;
  bit m_own_dm;
  bit m_we;
  logic [15:0] m_addr;
  logic [31:0] m_data;
  int m_ack_at;
  int m_free;
  int m_streak;
  logic [31:0] m_ird, m_drd;
  // Memory environment plus transaction-level reference: one access at a time, grant decided from the
  // inputs of the first free cycle, ack at issue+1 (write) or issue+L+1 (read).
  always @(negedge clk) begin
    bit e_en, dmw;
    bus.mem_rdata = (cyc == rd_due) ? memv(rd_addr) : {16'hBAD0, 16'(cyc)};
    if (bus.mem_en && bus.mem_we) mem[int'(bus.mem_addr)] = bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) begin
      rd_due  = cyc + L;
      rd_addr = bus.mem_addr;
    end
    if (cyc >= 2) begin
      if (p_rst) begin
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_ack", 32'(bus.if_ack), 0);
        chk("rst_dm_ack", 32'(bus.dm_ack), 0);
        m_busy = 0;
        m_free = cyc;
        m_streak = 0;
        m_ird = '0;
        m_drd = '0;
      end else begin
        e_en = !m_busy && (cyc - 1 >= m_free) && (p_if_req || p_dm_req);
        if (e_en) begin
          dmw = p_dm_req && !(p_if_req && m_streak == MAXS);
          m_streak = (dmw && p_if_req) ? m_streak + 1 : 0;
          m_own_dm = dmw;
          m_we = dmw && p_dm_we;
          m_addr = dmw ? p_dm_addr : p_if_addr;
          if (m_we) refm[int'(m_addr)] = p_dm_wdata;
          else m_data = refv(m_addr);
          m_ack_at = cyc + (m_we ? 1 : L + 1);
          m_busy = 1;
        end
        chk("mon_mem_en", 32'(bus.mem_en), 32'(e_en));
        chk("mon_mem_we", 32'(bus.mem_we), 32'(e_en && m_we));
        if (e_en) chk("mon_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (e_en && m_we) chk("mon_mem_wdata", bus.mem_wdata, p_dm_wdata);
        chk("mon_if_ack", 32'(bus.if_ack), 32'(m_busy && cyc == m_ack_at && !m_own_dm));
        chk("mon_dm_ack", 32'(bus.dm_ack), 32'(m_busy && cyc == m_ack_at && m_own_dm));
        if (m_busy && cyc == m_ack_at) begin
          if (!m_we && m_own_dm) m_drd = m_data;
          if (!m_we && !m_own_dm) m_ird = m_data;
          m_busy = 0;
          m_free = cyc + 1;
        end
      end
      chk("mon_if_rdata", bus.if_rdata, m_ird);
      chk("mon_dm_rdata", bus.dm_rdata, m_drd);
    end
  end
  int q_en[$];
  logic [15:0] q_ea[$];
  int q_ia[$];
  int q_da[$];
  logic [31:0] ird_at, drd_at;
  bit ia_prev, da_prev, dm_rep;
  task automatic clear_logs();
    q_en.delete();
    q_ea.delete();
    q_ia.delete();
    q_da.delete();
    ia_prev = 0;
    da_prev = 0;
  endtask
  // Cycle 0 is the current cycle; logs cycles 1..n, requesters drop the cycle after their ack
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        q_en.push_back(i);
        q_ea.push_back(bus.mem_addr);
      end
      if (bus.if_ack) begin
        q_ia.push_back(i);
        ird_at = bus.if_rdata;
      end
      if (bus.dm_ack) begin
        q_da.push_back(i);
        drd_at = bus.dm_rdata;
      end
      if (ia_prev) bus.if_req = 1'b0;
      if (da_prev && !dm_rep) bus.dm_req = 1'b0;
      ia_prev = bus.if_ack;
      da_prev = bus.dm_ack;
    end
  endtask
  typedef struct {
    logic i_req;
    logic d_req;
    logic d_we;
    logic [15:0] i_addr;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    int e_en;
    int e_ia;
    int e_da;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
    logic [31:0] e_ird_end;
    logic [31:0] e_drd_end;
  } vec_t;
  vec_t tbl[8];
  initial begin
    bit ia_p, da_p;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    bus.mem_rdata = '0;
    dm_rep = 0;
    set_mem(16'h0004, 32'h2008000A);
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 32'h0, 1, 4, -1, 32'h2008000A, 32'h0, 32'h2008000A, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010, 32'hDEADBEEF, 1, -1, 2, 32'h0, 32'h0, 32'h2008000A, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0010, 32'h0, 1, 9, 4, 32'h2008000A, 32'hDEADBEEF, 32'h2008000A, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 32'h12345678, 1, -1, 2, 32'h0, 32'hDEADBEEF, 32'h2008000A, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 32'h0, 1, -1, 4, 32'h0, 32'h12345678, 32'h2008000A, 32'h12345678};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 32'h0, 1, 4, -1, 32'h12345678, 32'h0, 32'h12345678, 32'h12345678};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 16'h0004, 16'h0030, 32'hAAAA5555, 1, 7, 2, 32'h2008000A, 32'h12345678, 32'h2008000A, 32'h12345678};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 32'h0, 1, 4, -1, 32'hAAAA5555, 32'h0, 32'hAAAA5555, 32'h12345678};
    repeat (3) @(negedge clk);
    chk("reset_mem_en", 32'(bus.mem_en), 0);
    chk("reset_if_ack", 32'(bus.if_ack), 0);
    chk("reset_dm_ack", 32'(bus.dm_ack), 0);
    chk("reset_if_rdata", bus.if_rdata, 0);
    chk("reset_dm_rdata", bus.dm_rdata, 0);
    chk("reset_streak", 32'(dut.u_grant.r_streak), 0);
    rst = 1'b0;
    @(negedge clk);
    foreach (tbl[k]) begin
      clear_logs();
      bus.if_req = tbl[k].i_req;
      bus.if_addr = tbl[k].i_addr;
      bus.dm_req = tbl[k].d_req;
      bus.dm_we = tbl[k].d_we;
      bus.dm_addr = tbl[k].d_addr;
      bus.dm_wdata = tbl[k].d_wdata;
      run(14);
      chk($sformatf("t%0d_first_en", k), 32'(q_en.size() > 0 ? q_en[0] : -1), 32'(tbl[k].e_en));
      chk($sformatf("t%0d_if_ack_cyc", k), 32'(q_ia.size() > 0 ? q_ia[0] : -1), 32'(tbl[k].e_ia));
      chk($sformatf("t%0d_dm_ack_cyc", k), 32'(q_da.size() > 0 ? q_da[0] : -1), 32'(tbl[k].e_da));
      if (tbl[k].e_ia >= 0) chk($sformatf("t%0d_if_rdata_ack", k), ird_at, tbl[k].e_ird);
      if (tbl[k].e_da >= 0) chk($sformatf("t%0d_dm_rdata_ack", k), drd_at, tbl[k].e_drd);
      chk($sformatf("t%0d_if_rdata_end", k), bus.if_rdata, tbl[k].e_ird_end);
      chk($sformatf("t%0d_dm_rdata_end", k), bus.dm_rdata, tbl[k].e_drd_end);
    end
    clear_logs();
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0040;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_addr = 16'h0050;
    dm_rep = 1;
    run(28);
    chk("starve_grants", 32'(q_en.size()), 6);
    for (int j = 0; j < q_ea.size() && j < 6; j++)
      chk($sformatf("starve_addr%0d", j), 32'(q_ea[j]), (j == 4) ? 32'h40 : 32'h50);
    chk("starve_if_ack", 32'(q_ia.size() > 0 ? q_ia[0] : -1), 24);
    chk("starve_resume_en", 32'(q_en.size() > 5 ? q_en[5] : -1), 26);
    dm_rep = 0;
    run(12);
    chk("starve_streak_end", 32'(dut.u_grant.r_streak), 0);
    clear_logs();
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0004;
    @(negedge clk);
    chk("rstmid_issue", 32'(bus.mem_en), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_mem_en", 32'(bus.mem_en), 0);
    chk("rstmid_mem_addr", 32'(bus.mem_addr), 0);
    chk("rstmid_if_ack", 32'(bus.if_ack), 0);
    chk("rstmid_if_rdata", bus.if_rdata, 0);
    chk("rstmid_dm_rdata", bus.dm_rdata, 0);
    rst = 1'b0;
    run(8);
    chk("rstmid_restart_en", 32'(q_en.size() > 0 ? q_en[0] : -1), 1);
    chk("rstmid_restart_ack", 32'(q_ia.size() > 0 ? q_ia[0] : -1), 4);
    chk("rstmid_restart_rdata", ird_at, 32'h2008000A);
    ia_p = 0;
    da_p = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      if (ia_p) begin
        if ($urandom_range(0, 1) == 1) bus.if_addr = 16'($urandom_range(0, 15));
        else bus.if_req = 1'b0;
      end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = 16'($urandom_range(0, 15));
      end
      if (da_p) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.dm_we = 1'($urandom_range(0, 1));
          bus.dm_addr = 16'($urandom_range(0, 15));
          bus.dm_wdata = $urandom;
        end else bus.dm_req = 1'b0;
      end else if (!bus.dm_req && $urandom_range(0, 1) == 0) begin
        bus.dm_req = 1'b1;
        bus.dm_we = 1'($urandom_range(0, 1));
        bus.dm_addr = 16'($urandom_range(0, 15));
        bus.dm_wdata = $urandom;
      end
      ia_p = bus.if_ack;
      da_p = bus.dm_ack;
    end
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the CPU's instruction-fetch port and data-memory port.
- Replaces the separate IM/DM interfaces at the top of the core with one memory port.
- Uses a fixed-latency read model and a request/acknowledge handshake; the core stalls until each acknowledge arrives.
- Data accesses have priority, with a streak limit so instruction fetch is never starved.

Parameters:
- data_size, 32, width of data words.
- mem_size, 16, width of word addresses.
- MEM_LATENCY, 2, cycles from the memory-enable cycle until mem_rdata is valid; legal values are 1 to 15.
- MAX_DM_STREAK, 4, maximum number of consecutive data grants while a fetch is waiting; legal values are 1 to 15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; level signal, held until if_ack.
- if_addr  in  mem_size  fetch word address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  data_size  fetched instruction; valid in the if_ack cycle, then held.
- dm_req  in  1  data request; level signal, held until dm_ack.
- dm_we  in  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  in  mem_size  data word address; stable while dm_req is high.
- dm_wdata  in  data_size  write data; stable while dm_req is high.
- dm_ack  out  1  one-cycle pulse; data access complete.
- dm_rdata  out  data_size  read data; valid in the dm_ack cycle, then held.
- mem_en  out  1  memory access strobe; high for exactly one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  mem_size  memory word address.
- mem_wdata  out  data_size  memory write data.
- mem_rdata  in  data_size  memory read data; valid MEM_LATENCY cycles after the mem_en cycle.

Behaviour:
- Reset:
  - All outputs are registered and reset to 0.
  - State goes to IDLE; the latency counter and streak counter clear.
  - Reset asserted mid-access abandons the access: no ack is issued and the captured rdata is discarded.
- FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE: if any request is high, latch the winner (owner, we, addr, wdata) and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_en=1, with mem_we/mem_addr/mem_wdata from the latched values.
    - Write: go to ACK.
    - Read: load counter = MEM_LATENCY−1, go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, capture mem_rdata into the owner's rdata register and go to ACK.
    - With MEM_LATENCY=1, WAIT lasts one cycle.
  - ACK: pulse the owner's ack for one cycle, then go to IDLE.
- Latency, counted from the first IDLE cycle in which the request is high to the ack cycle:
  - Read: MEM_LATENCY+2 cycles.
  - Write: 2 cycles.
  - Minimum back-to-back issue spacing is 3 cycles.
- Handshake:
  - The requester drops req, or presents a new request, in the cycle after ack.
  - A request seen in IDLE is always treated as a new request.
  - Request fields that change while owned are ignored, because the fields are latched in IDLE.
- Arbitration, evaluated in IDLE only:
  - Only one request high: it wins.
  - Both high: dm wins, unless dm_streak == MAX_DM_STREAK, in which case if wins.
  - dm_streak increments when dm wins while if_req is high; it saturates at MAX_DM_STREAK.
  - dm_streak clears when if wins, or when dm wins with if_req low.
- Write grants leave both rdata registers unchanged.
- Each ack only ever goes to the latched owner; if_ack and dm_ack are never high together.
- mem_we is never 1 while mem_en is 0.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3);
  - the owner encoding (OWN_IF=1'b0, OWN_DM=1'b1);
  - default MEM_LATENCY and MAX_DM_STREAK.
- One natural sub-module is mem_port_grant: the combinational winner select plus the registered streak counter.
- The FSM, latency counter and datapath registers stay in the top-level module.

Test Plan (all with MEM_LATENCY=2, MAX_DM_STREAK=4):
- Fetch read: cycle 0, if_req=1, if_addr=16'h0004, and the memory model returns 32'h2008000A → cycle 1 mem_en=1, mem_we=0, mem_addr=16'h0004; cycle 4 if_ack=1, if_rdata=32'h2008000A.
- Data write: cycle 0, dm_req=1, dm_we=1, dm_addr=16'h0010, dm_wdata=32'hDEADBEEF → cycle 1 mem_en=1, mem_we=1, mem_wdata=32'hDEADBEEF; cycle 2 dm_ack=1; dm_rdata unchanged.
- Simultaneous requests: if_req and dm_req (read) both high at cycle 0 → dm is granted first (dm_ack at cycle 4); the if access issues at cycle 6 and if_ack arrives at cycle 9.
- Starvation guard: if_req held high while dm_req re-requests continuously → exactly 4 dm grants, then 1 if grant, then dm grants resume; dm_streak returns to 0.
- Reset mid-read: rst=1 in the WAIT cycle → the next cycle has all outputs 0 and state IDLE, and no ack appears; after rst=0, a held if_req restarts with a fresh 4-cycle read.
- Write/read ordering: dm write 32'h12345678 to 16'h0020, then dm read of 16'h0020 → dm_rdata=32'h12345678 at the read's ack; if_rdata never changes during either access.
